// File: rtl/data_sram_slave.sv
// data_sram_slave: single-cycle SRAM-style slave holding a word RAM plus a
// small MMIO block (LED, SWITCH and a free-running TIMER).
//
// Ports
//   clk         rising-edge clock for all state
//   reset       synchronous active-high reset
//   sram_en     request valid this cycle
//   sram_we     byte-lane write enables (0 = read)
//   sram_addr   byte address, bits [1:0] ignored
//   sram_wdata  write data
//   sram_rdata  registered read data, valid the cycle after a request
//   switch_in   board switch levels
//   led_out     LED register
//   timer_out   current timer value
module data_sram_slave #(
  parameter int          RAM_AW    = 8,
  parameter logic [15:0] MMIO_BASE = 16'hbfaf
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sram_en,
  input  logic [3:0]  sram_we,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  input  logic [7:0]  switch_in,
  output logic [15:0] led_out,
  output logic [31:0] timer_out
);

  localparam logic [15:0] LED_OFF    = 16'hf000;
  localparam logic [15:0] SWITCH_OFF = 16'hf020;
  localparam logic [15:0] TIMER_OFF  = 16'he000;

  logic [31:0]       mem [2**RAM_AW];

  logic              is_mmio;
  logic [RAM_AW-1:0] word_idx;
  logic              is_write;
  logic              hit_led;
  logic              hit_switch;
  logic              hit_timer;
  logic [31:0]       mmio_rdata;
  logic [31:0]       led_merged;
  logic [31:0]       timer_merged;
  logic              unused_addr_bits;

  // Bits [1:0] and the aliased upper RAM bits carry no meaning here.
  assign unused_addr_bits = ^sram_addr;

  always_comb begin
    is_mmio    = (sram_addr[31:16] == MMIO_BASE);
    word_idx   = sram_addr[RAM_AW+1:2];
    is_write   = sram_en && (sram_we != 4'b0000);
    hit_led    = is_mmio && (sram_addr[15:2] == LED_OFF[15:2]);
    hit_switch = is_mmio && (sram_addr[15:2] == SWITCH_OFF[15:2]);
    hit_timer  = is_mmio && (sram_addr[15:2] == TIMER_OFF[15:2]);

    mmio_rdata = 32'h0;
    if (hit_led)    mmio_rdata = {16'h0, led_out};
    if (hit_switch) mmio_rdata = {24'h0, switch_in};
    if (hit_timer)  mmio_rdata = timer_out;

    // Merge written lanes over the current register values.
    led_merged   = {16'h0, led_out};
    timer_merged = timer_out;
    for (int i = 0; i < 4; i++) begin
      if (sram_we[i]) begin
        led_merged[8*i +: 8]   = sram_wdata[8*i +: 8];
        timer_merged[8*i +: 8] = sram_wdata[8*i +: 8];
      end
    end
  end

  // Registers and read port; the RAM read samples the pre-write word.
  always_ff @(posedge clk) begin
    if (reset) begin
      sram_rdata <= 32'h0;
      led_out    <= 16'h0;
      timer_out  <= 32'h0;
    end else begin
      if (sram_en) begin
        sram_rdata <= is_mmio ? mmio_rdata : mem[word_idx];
      end
      if (is_write && hit_led) begin
        led_out <= led_merged[15:0];
      end
      // A write takes priority over the increment for that cycle.
      if (is_write && hit_timer) begin
        timer_out <= timer_merged;
      end else begin
        timer_out <= timer_out + 32'd1;
      end
    end
  end

  // RAM contents are never reset; requests in a reset cycle are dropped.
  always_ff @(posedge clk) begin
    if (!reset && sram_en && !is_mmio) begin
      for (int i = 0; i < 4; i++) begin
        if (sram_we[i]) begin
          mem[word_idx][8*i +: 8] <= sram_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_sram_slave.sv
module tb_data_sram_slave;

  localparam int          AW    = 8;
  localparam int          WORDS = 2**AW;
  localparam logic [15:0] BASE  = 16'hbfaf;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sram_en = 1'b0;
  logic [3:0]  sram_we = 4'h0;
  logic [31:0] sram_addr = 32'h0;
  logic [31:0] sram_wdata = 32'h0;
  logic [31:0] sram_rdata;
  logic [7:0]  switch_in = 8'h0;
  logic [15:0] led_out;
  logic [31:0] timer_out;

  int checks = 0;
  int errors = 0;

  // Reference model: byte-granular RAM with per-byte "written" flags.
  logic [7:0]  m_bytes [4*WORDS];
  bit          m_valid [4*WORDS];
  logic [31:0] m_rdata;
  bit          m_rknown;
  logic [15:0] m_led;
  logic [31:0] m_timer;

  always #5 clk = ~clk;

  data_sram_slave #(.RAM_AW(AW), .MMIO_BASE(BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .switch_in  (switch_in),
    .led_out    (led_out),
    .timer_out  (timer_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed %08h expected %08h", tag, obs, exp);
      end
  endtask

  // One clock cycle: drive at negedge, advance the model, check after posedge.
  task automatic step(input bit rst, input bit en, input logic [3:0] we,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [7:0] sw);
    bit          mmio;
    int          w;
    int          off;
    logic [31:0] rd;
    logic [31:0] t_next;
    bit          known;
    @(negedge clk);
    reset      = rst;
    sram_en    = en;
    sram_we    = we;
    sram_addr  = addr;
    sram_wdata = wdata;
    switch_in  = sw;

    if (rst) begin
      m_rdata  = 32'h0;
      m_rknown = 1'b1;
      m_led    = 16'h0;
      m_timer  = 32'h0;
    end else begin
      mmio   = (addr[31:16] == BASE);
      w      = int'((addr >> 2) % WORDS);
      off    = int'(addr[15:0]) & 32'hfffc;
      t_next = m_timer + 32'd1;
      if (en && mmio) begin
        case (off)
          'hf000:  rd = {16'h0, m_led};
          'hf020:  rd = {24'h0, sw};
          'he000:  rd = m_timer;
          default: rd = 32'h0;
        endcase
        m_rdata  = rd;
        m_rknown = 1'b1;
        if (off == 'he000 && we != 4'h0) t_next = m_timer;
        for (int i = 0; i < 4; i++) begin
          if (we[i]) begin
            if (off == 'hf000 && i < 2) m_led[8*i +: 8] = wdata[8*i +: 8];
            if (off == 'he000) t_next[8*i +: 8] = wdata[8*i +: 8];
          end
        end
      end else if (en) begin
        known = 1'b1;
        for (int i = 0; i < 4; i++) begin
          rd[8*i +: 8] = m_bytes[4*w+i];
          if (!m_valid[4*w+i]) known = 1'b0;
        end
        m_rdata  = rd;
        m_rknown = known;
        for (int i = 0; i < 4; i++) begin
          if (we[i]) begin
            m_bytes[4*w+i] = wdata[8*i +: 8];
            m_valid[4*w+i] = 1'b1;
          end
        end
      end
      m_timer = t_next;
    end

    @(posedge clk);
    #1;
    check("led_out", {16'h0, led_out}, {16'h0, m_led});
    check("timer_out", timer_out, m_timer);
    if (m_rknown) check("sram_rdata", sram_rdata, m_rdata);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, switch_in);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] x;
    int          kind;
    for (int i = 0; i < 4*WORDS; i++) m_valid[i] = 1'b0;
    m_rknown = 1'b0;
    m_led    = 16'h0;
    m_timer  = 32'h0;
    m_rdata  = 32'h0;

    // Reset, including a RAM write that must be discarded.
    step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 8'h00);
    step(1'b1, 1'b1, 4'hf, 32'h1c00_0020, 32'h12345678, 8'h00);
    check("reset_rdata", sram_rdata, 32'h0);
    check("reset_timer", timer_out, 32'h0);
    idle();
    check("timer_restart", timer_out, 32'h1);

    // Full-word RAM write then read.
    step(1'b0, 1'b1, 4'hf, 32'h1c00_0010, 32'hdeadbeef, 8'h00);
    step(1'b0, 1'b1, 4'h0, 32'h1c00_0010, 32'h0, 8'h00);
    check("ram_full", sram_rdata, 32'hdeadbeef);

    // Single byte-lane write.
    step(1'b0, 1'b1, 4'b0010, 32'h1c00_0010, 32'h00001100, 8'h00);
    check("write_returns_old", sram_rdata, 32'hdeadbeef);
    step(1'b0, 1'b1, 4'h0, 32'h1c00_0010, 32'h0, 8'h00);
    check("ram_lane", sram_rdata, 32'hdead11ef);

    // Read-before-write.
    step(1'b0, 1'b1, 4'hf, 32'h0000_0040, 32'h5, 8'h00);
    step(1'b0, 1'b1, 4'hf, 32'h0000_0040, 32'h1, 8'h00);
    check("rbw_old", sram_rdata, 32'h5);
    step(1'b0, 1'b1, 4'h0, 32'h0000_0040, 32'h0, 8'h00);
    check("rbw_new", sram_rdata, 32'h1);

    // Holding rdata while idle.
    idle();
    check("rdata_hold", sram_rdata, 32'h1);

    // Aliasing: upper address bits beyond the RAM index are ignored.
    step(1'b0, 1'b1, 4'h0, 32'h7700_0410, 32'h0, 8'h00);
    check("ram_alias", sram_rdata, 32'hdead11ef);

    // Timer write priority and wrap.
    step(1'b0, 1'b1, 4'hf, {BASE, 16'he000}, 32'hfffffffe, 8'h00);
    check("timer_write", timer_out, 32'hfffffffe);
    idle();
    check("timer_ff", timer_out, 32'hffffffff);
    idle();
    check("timer_wrap", timer_out, 32'h0);

    // MMIO registers.
    step(1'b0, 1'b1, 4'hf, {BASE, 16'hf000}, 32'h0001a5a5, 8'h00);
    check("led_write", {16'h0, led_out}, 32'h0000a5a5);
    step(1'b0, 1'b1, 4'h0, {BASE, 16'hf020}, 32'h0, 8'h3c);
    check("switch_read", sram_rdata, 32'h0000003c);
    step(1'b0, 1'b1, 4'hf, {BASE, 16'hf100}, 32'hffffffff, 8'h3c);
    check("unmapped_read", sram_rdata, 32'h0);
    step(1'b0, 1'b1, 4'h0, {BASE, 16'hf000}, 32'h0, 8'h3c);
    check("led_read", sram_rdata, 32'h0000a5a5);

    // Randomized mix of RAM and MMIO traffic.
    for (int n = 0; n < 500; n++) begin
      kind = int'($urandom_range(0, 99));
      a = $urandom;
      if (kind < 55) begin
        x = $urandom_range(0, 15);
        a[AW+1:2] = x[AW-1:0];
        if (a[31:16] == BASE) a[31:16] = 16'h1c00;
      end else begin
        case ($urandom_range(0, 3))
          0:       a[15:2] = 14'h3c00;
          1:       a[15:2] = 14'h3c08;
          2:       a[15:2] = 14'h3800;
          default: a[15:2] = 14'(32'($urandom));
        endcase
        a[31:16] = BASE;
      end
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 80,
           ($urandom_range(0, 1) == 1) ? 4'(32'($urandom)) : 4'h0,
           a, $urandom, 8'(32'($urandom)));
    end

    // Reset in the middle of a LED write: the write is lost.
    step(1'b0, 1'b1, 4'hf, {BASE, 16'hf000}, 32'h0000_1234, 8'h00);
    step(1'b1, 1'b1, 4'hf, {BASE, 16'hf000}, 32'h0000_ffff, 8'h00);
    check("rst_led", {16'h0, led_out}, 32'h0);
    check("rst_rdata", sram_rdata, 32'h0);
    check("rst_timer", timer_out, 32'h0);
    idle();
    check("rst_timer_next", timer_out, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_sram_slave.md
DATA_SRAM_SLAVE -- requirements
Module: data_sram_slave

Interface
REQ-001 SHALL have parameter RAM_AW, default 8: RAM word-address width, giving 2^RAM_AW 32-bit words.
REQ-002 SHALL have parameter MMIO_BASE, default 16'hbfaf: value of addr[31:16] that selects the MMIO region.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port sram_en, input, 1: request valid this cycle.
REQ-006 SHALL have port sram_we, input, 4: byte-lane write enables; lane i covers wdata[8i+7:8i]; 0 means read.
REQ-007 SHALL have port sram_addr, input, 32: byte address; bits [1:0] ignored.
REQ-008 SHALL have port sram_wdata, input, 32: write data.
REQ-009 SHALL have port sram_rdata, output, 32: registered read data.
REQ-010 SHALL have port switch_in, input, 8: board switch levels.
REQ-011 SHALL have port led_out, output, 16: LED register value.
REQ-012 SHALL have port timer_out, output, 32: current timer value.

Function
REQ-013 SHALL decode addr[31:16]==MMIO_BASE as MMIO; all other addresses as RAM at word index addr[RAM_AW+1:2], with upper bits aliasing.
REQ-014 SHALL return read data on sram_rdata exactly one cycle after a cycle with sram_en=1; there are no wait states and a request is accepted every cycle.
REQ-015 SHALL hold sram_rdata at its last value in every cycle that follows sram_en=0.
REQ-016 SHALL update sram_rdata on every cycle with sram_en=1, including writes: a write returns the pre-write word at its address.
REQ-017 SHALL update, on a RAM write (sram_en=1, sram_we!=0), only the byte lanes with sram_we[i]=1; other lanes keep their value.
REQ-018 SHALL be read-before-write on RAM: a same-cycle read of the address being written returns the old word.
REQ-019 SHALL define MMIO register LED at offset 16'hf000: RW; bits [15:0] byte-lane writable; reads zero-extended; drives led_out.
REQ-020 SHALL define MMIO register SWITCH at offset 16'hf020: RO, read as {24'b0, switch_in} sampled in the request cycle; writes ignored.
REQ-021 SHALL define MMIO register TIMER at offset 16'he000: RW, byte-lane writable; increments by 1 every cycle it is not written; wraps 32'hffffffff to 0; drives timer_out.
REQ-022 SHALL give a TIMER write priority over the increment: after the write the value equals the written lanes merged with the pre-write value, not incremented that cycle.
REQ-023 SHALL make a TIMER read return the value present in the request cycle, before that cycle's increment.
REQ-024 SHALL make reads of unmapped MMIO offsets return 32'h0 and make writes to them no effect.
REQ-025 SHALL have no combinational path from any input to sram_rdata, led_out or timer_out.

Reset
REQ-026 SHALL, with reset=1 at a clock edge, set sram_rdata=0, led_out=0 and timer_out=0.
REQ-027 SHALL, on reset, discard any request issued in the reset cycle, with no write effect and no read response.
REQ-028 SHALL NOT reset RAM contents; RAM reads before the first write are undefined.
REQ-029 SHALL restart TIMER from 0 in the first cycle after reset deasserts.

Verification
REQ-030 SHALL cover a RAM full write then read: write 32'hdeadbeef, we=4'hf, to 0x1c00_0010; next cycle read the same address -> rdata=32'hdeadbeef one cycle after the read.
REQ-031 SHALL cover byte lanes: after REQ-030, write 32'h00001100 with we=4'b0010 to 0x1c00_0010 -> a read returns 32'hdead11ef.
REQ-032 SHALL cover read-before-write: in one cycle write 32'h1 to address X, which holds 32'h5 -> rdata=32'h5 next cycle; a read in the following cycle -> 32'h1.
REQ-033 SHALL cover timer priority and wrap: write TIMER=32'hfffffffe -> timer_out=32'hfffffffe, then 32'hffffffff, then 32'h0 on successive cycles.
REQ-034 SHALL cover MMIO registers: write LED 32'h0001a5a5 -> led_out=16'ha5a5; with switch_in=8'h3c, read SWITCH -> 32'h0000003c; read 0xbfaf_f100 -> 32'h0.
REQ-035 SHALL cover reset mid-operation: assert reset during a LED write of 32'hffff -> led_out=0, sram_rdata=0, timer_out=0 next cycle; the write is lost.
